// File: rtl/aes_dec_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_dec_round_ctrl
// Description : Iterative AES-128 decryption round controller. It applies the
//               initial AddRoundKey, sequences ten passes through an external
//               registered inverse-round chain, and returns the plaintext
//               through a valid/ready handshake.
//               Optional feature macro: AES_DEC_CTRL_ABORT_EN adds an abort
//               input that cancels the block in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_dec_round_ctrl #(
    parameter int STAGE_LAT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   key_idx,
    input  logic [127:0] rnd_key,
    output logic [127:0] dp_state,
    output logic         dp_last,
    input  logic [127:0] dp_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
`ifdef AES_DEC_CTRL_ABORT_EN
    input  logic         abort,
`endif
    output logic         busy
);

    localparam logic [3:0] c_last_cnt    = 4'(STAGE_LAT - 1);
    localparam logic [3:0] c_key_idle    = 4'd10;
    localparam logic [3:0] c_first_round = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [127:0] r_st;
    logic [127:0] w_st_nxt;
    logic [3:0]   r_round;
    logic [3:0]   w_round_nxt;
    logic [3:0]   r_cnt;
    logic [3:0]   w_cnt_nxt;
    logic         w_abort;
    logic         w_in_flight;

`ifdef AES_DEC_CTRL_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_st    <= '0;
            r_round <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_st    <= w_st_nxt;
            r_round <= w_round_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_st_nxt    = r_st;
        w_round_nxt = r_round;
        w_cnt_nxt   = r_cnt;
        w_in_flight = (r_state == S_LAUNCH) || (r_state == S_WAIT);

        in_ready    = (r_state == S_IDLE) && !rst;
        busy        = (r_state != S_IDLE);
        key_idx     = c_key_idle;
        dp_state    = '0;
        dp_last     = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;

        // The chain sees a quiet zero input whenever no round is in progress
        if (w_in_flight) begin
            key_idx  = r_round;
            dp_state = r_st;
            dp_last  = (r_round == 4'd0);
        end

        if (r_state == S_DONE) begin
            out_valid = 1'b1;
            out_data  = r_st;
        end

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_st_nxt    = in_data ^ rnd_key;
                    w_round_nxt = c_first_round;
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt + 4'd1;
                if (r_cnt == c_last_cnt) begin
                    w_st_nxt = dp_result;
                    if (r_round == 4'd0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_round_nxt = r_round - 4'd1;
                        w_state_nxt = S_LAUNCH;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Abort outranks a simultaneous output handshake
        if (w_abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_dec_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_dec_round_ctrl
// Description : Bench for aes_dec_round_ctrl with a real AES inverse-round
//               chain, key store and a whole-block decryption reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_dec_round_ctrl;

    localparam int STAGE_LAT = 4;
    localparam int TOT       = 10 * (STAGE_LAT + 1);

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   key_idx;
    logic [127:0] rnd_key;
    logic [127:0] dp_state;
    logic         dp_last;
    logic [127:0] dp_result;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
`ifdef AES_DEC_CTRL_ABORT_EN
    logic         abort;
`endif

    always #5 clk = ~clk;

    aes_dec_round_ctrl #(.STAGE_LAT(STAGE_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .key_idx   (key_idx),
        .rnd_key   (rnd_key),
        .dp_state  (dp_state),
        .dp_last   (dp_last),
        .dp_result (dp_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef AES_DEC_CTRL_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy)
    );

    logic [7:0]   sbox  [0:255];
    logic [7:0]   isbox [0:255];
    logic [127:0] rk    [0:10];
    logic [127:0] pre   [0:9];
    logic [127:0] exp_pt;
    logic [127:0] pipe  [0:STAGE_LAT-1];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_cur    = 0;
    int acc_cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- AES arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] inv;
            logic [7:0] s;
            inv = 8'h00;
            if (v != 0) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(v));
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[v]  = s;
            isbox[s] = 8'(v);
        end
    endtask

    task automatic set_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
                t = t ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last
    function automatic logic [127:0] inv_round(input logic [127:0] s,
                                               input logic [127:0] k,
                                               input logic last);
        logic [7:0]   a [0:15];
        logic [7:0]   b [0:15];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[r+4*c] = isbox[a[r + 4*((c + 4 - r) % 4)]] ^ k[127-8*(r+4*c) -: 8];
        for (int i = 0; i < 16; i++) a[i] = b[i];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a[4*c]   = gmul(b[4*c],8'h0e) ^ gmul(b[4*c+1],8'h0b) ^ gmul(b[4*c+2],8'h0d) ^ gmul(b[4*c+3],8'h09);
                a[4*c+1] = gmul(b[4*c],8'h09) ^ gmul(b[4*c+1],8'h0e) ^ gmul(b[4*c+2],8'h0b) ^ gmul(b[4*c+3],8'h0d);
                a[4*c+2] = gmul(b[4*c],8'h0d) ^ gmul(b[4*c+1],8'h09) ^ gmul(b[4*c+2],8'h0e) ^ gmul(b[4*c+3],8'h0b);
                a[4*c+3] = gmul(b[4*c],8'h0b) ^ gmul(b[4*c+1],8'h0d) ^ gmul(b[4*c+2],8'h09) ^ gmul(b[4*c+3],8'h0e);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = a[i];
        return o;
    endfunction

    // External key store and STAGE_LAT-deep registered round chain
    assign rnd_key = (key_idx <= 4'd10) ? rk[key_idx] : '0;

    always @(posedge clk) begin
        pipe[0] <= inv_round(dp_state, rnd_key, dp_last);
        for (int i = 1; i < STAGE_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign dp_result = pipe[STAGE_LAT-1];

    // ---------------- reference and checking ----------------
    task automatic model_block(input logic [127:0] ct);
        logic [127:0] s;
        s = ct ^ rk[10];
        for (int r = 9; r >= 0; r--) begin
            pre[r] = s;
            s = inv_round(s, rk[r], r == 0);
        end
        exp_pt = s;
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // n counts cycles after the accepting edge; cycle TOT+1 is the output cycle
    task automatic check_cycle(input int n);
        int rnd;
        if (n <= TOT) begin
            rnd = 9 - (n - 1) / (STAGE_LAT + 1);
            check("key_idx", 128'(key_idx), 128'(rnd));
            check("dp_last", 128'(dp_last), 128'(rnd == 0));
            check("dp_state", dp_state, pre[rnd]);
            check("out_valid_early", 128'(out_valid), 128'(0));
        end else begin
            check("out_valid", 128'(out_valid), 128'(1));
            check("out_data", out_data, exp_pt);
            check("key_idx_done", 128'(key_idx), 128'(10));
            check("dp_state_done", dp_state, 128'(0));
            check("dp_last_done", 128'(dp_last), 128'(0));
        end
        check("busy", 128'(busy), 128'(1));
        check("in_ready_busy", 128'(in_ready), 128'(0));
    endtask

    task automatic check_idle(input string tag, input logic exp_rdy);
        check({tag, "_in_ready"}, 128'(in_ready), 128'(exp_rdy));
        check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        check({tag, "_out_data"}, out_data, 128'(0));
        check({tag, "_dp_state"}, dp_state, 128'(0));
        check({tag, "_dp_last"}, 128'(dp_last), 128'(0));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_key_idx"}, 128'(key_idx), 128'(10));
    endtask

    task automatic accept_block(input logic [127:0] ct, input logic hold_valid);
        int t;
        t = 0;
        model_block(ct);
        in_data  = ct;
        in_valid = 1'b1;
        while (!in_ready && t < 400) begin
            step();
            t++;
        end
        if (t >= 400) check("accept_timeout", 128'(in_ready), 128'(1));
        step();
        acc_cyc = cyc;
        n_cur   = 1;
        if (!hold_valid) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = rand128();
        end
    endtask

    task automatic track(input int k);
        for (int i = 0; i < k; i++) begin
            check_cycle(n_cur);
            n_cur++;
            step();
        end
    endtask

    task automatic deliver(input int stall, input logic hold_valid);
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            check_cycle(n_cur);
            step();
        end
        out_ready = 1'b1;
        check_cycle(n_cur);
        step();
        if (!hold_valid) in_valid = 1'b0;
        check("in_ready_after", 128'(in_ready), 128'(1));
        check("out_valid_after", 128'(out_valid), 128'(0));
        check("busy_after", 128'(busy), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int prev;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef AES_DEC_CTRL_ABORT_EN
        abort     = 1'b0;
`endif
        build_sbox();
        set_key(128'h000102030405060708090a0b0c0d0e0f);
        repeat (3) step();
        check_idle("reset", 1'b0);
        rst = 1'b0;
        step();
        check("in_ready_release", 128'(in_ready), 128'(1));

        // FIPS-197 C.1 known answer
        out_ready = 1'b1;
        accept_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0);
        track(TOT);
        check("fips_pt", out_data, 128'h00112233445566778899aabbccddeeff);
        deliver(0, 1'b0);

        // Back-pressure: 20 stalled cycles in the output state
        set_key(rand128());
        accept_block(rand128(), 1'b0);
        track(TOT);
        deliver(20, 1'b0);

        // Back-to-back blocks with in_valid and out_ready held high
        set_key(rand128());
        out_ready = 1'b1;
        prev = 0;
        for (int b = 0; b < 3; b++) begin
            accept_block(rand128(), 1'b1);
            if (b > 0) check("b2b_spacing", 128'(acc_cyc - prev), 128'(TOT + 2));
            prev = acc_cyc;
            track(TOT);
            deliver(0, 1'b1);
        end
        in_valid = 1'b0;
        step();

        // Random keys, ciphertexts and stalls
        for (int b = 0; b < 4; b++) begin
            set_key(rand128());
            accept_block(rand128(), 1'b0);
            track(TOT);
            deliver(int'($urandom_range(0, 6)), 1'b0);
        end

        // Reset during round 5, then a fresh known-answer block
        set_key(128'h000102030405060708090a0b0c0d0e0f);
        accept_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0);
        track(4 * (STAGE_LAT + 1) + 1);
        check("key_idx_round5", 128'(key_idx), 128'(5));
        rst = 1'b1;
        step();
        check_idle("midrst", 1'b0);
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        check("in_ready_midrst", 128'(in_ready), 128'(1));
        accept_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0);
        track(TOT);
        check("fips_pt_after_rst", out_data, 128'h00112233445566778899aabbccddeeff);
        deliver(0, 1'b0);

`ifdef AES_DEC_CTRL_ABORT_EN
        // Abort in WAIT of round 3
        set_key(rand128());
        accept_block(rand128(), 1'b0);
        track(6 * (STAGE_LAT + 1) + 1);
        abort = 1'b1;
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        check_idle("abort_wait", 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_out", 128'(out_valid), 128'(0));
        end

        // Abort coinciding with the output handshake
        accept_block(rand128(), 1'b0);
        track(TOT);
        abort     = 1'b1;
        out_ready = 1'b1;
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        check_idle("abort_done", 1'b1);

        accept_block(rand128(), 1'b0);
        track(TOT);
        deliver(2, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
